// File: rtl/m72_irq_pkg.sv
// m72_irq_pkg: shared types and constants for the m72 interrupt controller.
// Optional feature macro: IRQ_AUTO_EOI_EN (second INTA retires the in-service bit).
package m72_irq_pkg;

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LEVEL_W    = 3;
  localparam int unsigned BASE_W     = 5;

  // Command byte bit positions (port A0=0)
  localparam int unsigned CMD_RDSEL = 3;
  localparam int unsigned CMD_INIT  = 4;
  localparam int unsigned CMD_EOI   = 5;

  localparam logic [NUM_LEVELS-1:0] IMR_RESET      = 8'hFF;
  localparam logic [LEVEL_W-1:0]    SPURIOUS_LEVEL = 3'd7;

  // Acknowledge sequencer: waiting for first INTA, or for the second one
  typedef enum logic {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } ack_state_e;

  // One-hot mask for a priority level
  function automatic logic [NUM_LEVELS-1:0] level_bit(input logic [LEVEL_W-1:0] lvl);
    return 8'h01 << lvl;
  endfunction

endpackage

// File: rtl/m72_irq_ctrl_prio8.sv
// irq_prio8: combinational fixed-priority encoder, bit 0 highest priority.
module irq_prio8
  import m72_irq_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] req,
  output logic                  valid_c,
  output logic [LEVEL_W-1:0]    index_c
);

  // Scan from lowest priority upward so the lowest set index wins
  always_comb begin
    valid_c = 1'b0;
    index_c = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid_c = 1'b1;
        index_c = LEVEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/m72_irq_ctrl.sv
// m72_irq_ctrl: 8-level edge-triggered interrupt controller (uPD71059 subset).
// Optional feature macro: IRQ_AUTO_EOI_EN -- when defined, the second INTA
// clears the acknowledged ISR bit; otherwise ISR clears only via EOI command.
module m72_irq_ctrl
  import m72_irq_pkg::*;
(
  input  logic                  CLK_32M,
  input  logic                  RESET,
  input  logic [NUM_LEVELS-1:0] IR,
  input  logic                  IO_WR,
  input  logic                  IO_RD,
  input  logic                  IO_A0,
  input  logic [7:0]            IO_DIN,
  output logic [7:0]            IO_DOUT,
  input  logic                  INTA,
  output logic                  INTR,
  output logic [7:0]            INT_VECTOR
);

  logic [NUM_LEVELS-1:0] irr, isr, imr, ir_prev;
  logic [NUM_LEVELS-1:0] irr_nxt, isr_nxt;
  logic [BASE_W-1:0]     base;
  logic                  expect_base;
  logic                  read_sel;
  ack_state_e            state, state_nxt;

  logic                  wr_cmd_c, wr_data_c, init_c, eoi_c;
  logic                  ack_first_c;
  logic [NUM_LEVELS-1:0] edge_c, higher_c, elig_c;
  logic                  isr_valid_c, elig_valid_c;
  logic [LEVEL_W-1:0]    isr_lvl_c, elig_lvl_c;

  assign wr_cmd_c    = IO_WR & ~IO_A0;
  assign wr_data_c   = IO_WR & IO_A0;
  assign init_c      = wr_cmd_c & IO_DIN[CMD_INIT];
  assign eoi_c       = wr_cmd_c & IO_DIN[CMD_EOI];
  assign ack_first_c = INTA & (state == IDLE);
  assign edge_c      = IR & ~ir_prev;

  // Highest level currently in service
  irq_prio8 u_isr_prio (
    .req     (isr),
    .valid_c (isr_valid_c),
    .index_c (isr_lvl_c)
  );

  // Only levels strictly above the in-service level may interrupt
  assign higher_c = isr_valid_c ? (level_bit(isr_lvl_c) - 8'h01) : IMR_RESET;
  assign elig_c   = irr & ~imr & higher_c;

  // Highest eligible pending request
  irq_prio8 u_elig_prio (
    .req     (elig_c),
    .valid_c (elig_valid_c),
    .index_c (elig_lvl_c)
  );

`ifdef IRQ_AUTO_EOI_EN
  logic               ack_real;
  logic [LEVEL_W-1:0] ack_level;
  logic               ack_second_c;
  assign ack_second_c = INTA & (state == ACK1);

  // Remember which level the first INTA granted so the second can retire it
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      ack_real  <= 1'b0;
      ack_level <= '0;
    end else if (ack_first_c) begin
      ack_real  <= elig_valid_c;
      ack_level <= elig_lvl_c;
    end
  end
`endif

  // Acknowledge sequencer next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (INTA) state_nxt = ACK1;
      ACK1:    if (INTA) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Acknowledge sequencer state register
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // IRR/ISR update: ack clear then new edge (edge wins); EOI before ack set; init overrides all
  always_comb begin
    irr_nxt = irr;
    isr_nxt = isr;
    if (ack_first_c && elig_valid_c) irr_nxt = irr_nxt & ~level_bit(elig_lvl_c);
    irr_nxt = irr_nxt | edge_c;
    if (eoi_c && isr_valid_c) isr_nxt = isr_nxt & ~level_bit(isr_lvl_c);
`ifdef IRQ_AUTO_EOI_EN
    if (ack_second_c && ack_real) isr_nxt = isr_nxt & ~level_bit(ack_level);
`endif
    if (ack_first_c && elig_valid_c) isr_nxt = isr_nxt | level_bit(elig_lvl_c);
    if (init_c) begin
      irr_nxt = '0;
      isr_nxt = '0;
    end
  end

  // Request/service registers and edge history
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      irr     <= '0;
      isr     <= '0;
      ir_prev <= IMR_RESET;
    end else begin
      irr     <= irr_nxt;
      isr     <= isr_nxt;
      ir_prev <= IR;
    end
  end

  // Programming registers: init sequence, vector base, mask, read select
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      imr         <= IMR_RESET;
      base        <= '0;
      expect_base <= 1'b0;
      read_sel    <= 1'b0;
    end else begin
      if (wr_cmd_c) read_sel <= IO_DIN[CMD_RDSEL];
      if (init_c) begin
        imr         <= IMR_RESET;
        expect_base <= 1'b1;
      end else if (wr_data_c) begin
        if (expect_base) begin
          base        <= IO_DIN[7:3];
          expect_base <= 1'b0;
        end else begin
          imr <= IO_DIN;
        end
      end
    end
  end

  // Registered CPU-facing outputs: request line, read data, vector
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      INTR       <= 1'b0;
      IO_DOUT    <= '0;
      INT_VECTOR <= '0;
    end else begin
      INTR <= |elig_c;
      if (IO_RD) IO_DOUT <= IO_A0 ? imr : (read_sel ? isr : irr);
      if (ack_first_c) INT_VECTOR <= {base, elig_valid_c ? elig_lvl_c : SPURIOUS_LEVEL};
    end
  end

endmodule

// File: tb/tb_m72_irq_ctrl.sv
// tb_m72_irq_ctrl: directed self-checking bench for m72_irq_ctrl.
// Default build checks the EOI-command flow; with IRQ_AUTO_EOI_EN the auto-EOI flow.
module tb_m72_irq_ctrl;

  logic       CLK_32M = 1'b0;
  logic       RESET   = 1'b1;
  logic [7:0] IR      = 8'h00;
  logic       IO_WR   = 1'b0;
  logic       IO_RD   = 1'b0;
  logic       IO_A0   = 1'b0;
  logic [7:0] IO_DIN  = 8'h00;
  logic [7:0] IO_DOUT;
  logic       INTA    = 1'b0;
  logic       INTR;
  logic [7:0] INT_VECTOR;

  int checks = 0;
  int errors = 0;

  m72_irq_ctrl dut (
    .CLK_32M    (CLK_32M),
    .RESET      (RESET),
    .IR         (IR),
    .IO_WR      (IO_WR),
    .IO_RD      (IO_RD),
    .IO_A0      (IO_A0),
    .IO_DIN     (IO_DIN),
    .IO_DOUT    (IO_DOUT),
    .INTA       (INTA),
    .INTR       (INTR),
    .INT_VECTOR (INT_VECTOR)
  );

  always #5 CLK_32M = ~CLK_32M;

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic io_write(input logic a0, input logic [7:0] d);
    IO_WR = 1'b1; IO_A0 = a0; IO_DIN = d;
    tick();
    IO_WR = 1'b0; IO_DIN = 8'h00;
  endtask

  task automatic io_read(input logic a0, output logic [7:0] d);
    IO_RD = 1'b1; IO_A0 = a0;
    tick();
    IO_RD = 1'b0;
    d = IO_DOUT;
  endtask

  task automatic inta_pulse();
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
  endtask

  task automatic pulse_ir(input logic [7:0] lines);
    IR = lines;
    tick();
    IR = 8'h00;
    tick();
  endtask

  task automatic program_ctrl(input logic [7:0] base_byte, input logic [7:0] mask);
    io_write(1'b0, 8'h10);
    io_write(1'b1, base_byte);
    io_write(1'b1, mask);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RESET = 1'b1;
    IR = 8'h04;
    tick(); tick();
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b expected 0", INTR); end
    checks++; if (IO_DOUT !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", IO_DOUT); end
    checks++; if (INT_VECTOR !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h expected 00", INT_VECTOR); end
    RESET = 1'b0;
    tick(); tick();
    io_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_high_line_irr: got %h expected 00", d); end
    io_read(1'b1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL reset_imr: got %h expected FF", d); end
    IR = 8'h00;
    tick();
  endtask

  task automatic test_init_ack();
    logic [7:0] d;
    program_ctrl(8'h40, 8'hFA);
    IR = 8'h01;
    tick();
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL init_intr_edge_k: got %b expected 0", INTR); end
    IR = 8'h00;
    tick();
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL init_intr_edge_k1: got %b expected 1", INTR); end
    inta_pulse();
    checks++; if (INT_VECTOR !== 8'h40) begin errors++; $display("FAIL init_vector_first: got %h expected 40", INT_VECTOR); end
    inta_pulse();
    checks++; if (INT_VECTOR !== 8'h40) begin errors++; $display("FAIL init_vector_hold: got %h expected 40", INT_VECTOR); end
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL init_intr_after_ack: got %b expected 0", INTR); end
    io_write(1'b0, 8'h08);
    io_read(1'b0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL init_isr: got %h expected 01", d); end
    io_write(1'b0, 8'h20);
  endtask

  task automatic test_same_cycle();
    pulse_ir(8'h05);
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL same_intr: got %b expected 1", INTR); end
    inta_pulse(); inta_pulse();
    checks++; if (INT_VECTOR !== 8'h40) begin errors++; $display("FAIL same_vector0: got %h expected 40", INT_VECTOR); end
    tick(); tick();
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL same_intr_blocked: got %b expected 0", INTR); end
    io_write(1'b0, 8'h20);
    tick();
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL same_intr_after_eoi: got %b expected 1", INTR); end
    inta_pulse(); inta_pulse();
    checks++; if (INT_VECTOR !== 8'h42) begin errors++; $display("FAIL same_vector2: got %h expected 42", INT_VECTOR); end
  endtask

  task automatic test_nested();
    logic [7:0] d;
    pulse_ir(8'h01);
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL nest_intr: got %b expected 1", INTR); end
    inta_pulse(); inta_pulse();
    checks++; if (INT_VECTOR !== 8'h40) begin errors++; $display("FAIL nest_vector: got %h expected 40", INT_VECTOR); end
    io_write(1'b0, 8'h08);
    io_read(1'b0, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL nest_isr: got %h expected 05", d); end
    io_write(1'b0, 8'h28);
    io_read(1'b0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL nest_eoi_bit0: got %h expected 04", d); end
    io_write(1'b0, 8'h20);
  endtask

  task automatic test_mask();
    logic [7:0] d;
    io_write(1'b1, 8'hFF);
    pulse_ir(8'h01);
    tick();
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL mask_intr_masked: got %b expected 0", INTR); end
    io_read(1'b0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL mask_irr: got %h expected 01", d); end
    io_write(1'b1, 8'hFE);
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL mask_intr_same: got %b expected 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL mask_intr_unmasked: got %b expected 1", INTR); end
    inta_pulse(); inta_pulse();
    io_write(1'b0, 8'h20);
  endtask

  task automatic test_spurious_reset();
    logic [7:0] d;
    inta_pulse();
    checks++; if (INT_VECTOR !== 8'h47) begin errors++; $display("FAIL spur_vector: got %h expected 47", INT_VECTOR); end
    inta_pulse();
    io_write(1'b0, 8'h08);
    io_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h expected 00", d); end
    io_write(1'b0, 8'h00);
    pulse_ir(8'h01);
    inta_pulse();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL rst_mid_intr: got %b expected 0", INTR); end
    checks++; if (INT_VECTOR !== 8'h00) begin errors++; $display("FAIL rst_mid_vector: got %h expected 00", INT_VECTOR); end
    io_read(1'b1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rst_mid_imr: got %h expected FF", d); end
    program_ctrl(8'h40, 8'hFE);
    pulse_ir(8'h01);
    inta_pulse();
    checks++; if (INT_VECTOR !== 8'h40) begin errors++; $display("FAIL rst_mid_fsm_idle: got %h expected 40", INT_VECTOR); end
    inta_pulse();
  endtask

  task automatic test_auto_eoi();
    logic [7:0] d;
    program_ctrl(8'h40, 8'hFE);
    pulse_ir(8'h01);
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL auto_intr: got %b expected 1", INTR); end
    inta_pulse(); inta_pulse();
    checks++; if (INT_VECTOR !== 8'h40) begin errors++; $display("FAIL auto_vector: got %h expected 40", INT_VECTOR); end
    io_write(1'b0, 8'h08);
    io_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL auto_isr: got %h expected 00", d); end
    pulse_ir(8'h01);
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL auto_reraise: got %b expected 1", INTR); end
  endtask

  initial begin
    test_reset();
`ifdef IRQ_AUTO_EOI_EN
    test_auto_eoi();
`else
    test_init_ack();
    test_same_cycle();
    test_nested();
    test_mask();
    test_spurious_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
